// File: rtl/div_ctrl_if.sv
// Configuration handshake bundle for div_ctrl: a new divide ratio and one-shot
// setup offered with valid/ready.
interface div_ctrl_if #(
    parameter int CNT_W = 28
) ();
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_oneshot;
    logic [7:0]       cfg_pulses;

    modport master (
        output cfg_valid, cfg_div, cfg_oneshot, cfg_pulses,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_div, cfg_oneshot, cfg_pulses,
        output cfg_ready
    );
endinterface

// File: rtl/div_ctrl.sv
// Tick/clock-divider controller: holds the divide ratio, runs continuous or
// one-shot, and emits a one-cycle tick enable, a toggling hz and status pulses.
module div_ctrl #(
    parameter int          CNT_W   = 28,
    parameter int unsigned DEF_DIV = 100_000_000
) (
    input  logic      Mhz,
    input  logic      RST,
    div_ctrl_if.slave cfg,
    input  logic      start,
    input  logic      stop,
    output logic      tick,
    output logic      hz,
    output logic      busy,
    output logic      done,
    output logic      err
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] div_reg, div_n;
    logic [CNT_W-1:0] count, count_n;
    logic             oneshot_reg, oneshot_n;
    logic [7:0]       pulses_reg, pulses_n;
    logic [7:0]       remaining, remaining_n;
    logic             tick_n, hz_n, busy_n, done_n, err_n;
    logic             xfer, cfg_bad, wrap;

    assign cfg.cfg_ready = (state == IDLE);
    assign xfer    = cfg.cfg_valid && (state == IDLE);
    assign cfg_bad = (cfg.cfg_div < CNT_W'(2)) || (cfg.cfg_oneshot && (cfg.cfg_pulses == 8'd0));
    assign wrap    = (count == div_reg - CNT_W'(1));

    always_comb begin
        state_n     = state;
        div_n       = div_reg;
        oneshot_n   = oneshot_reg;
        pulses_n    = pulses_reg;
        count_n     = count;
        remaining_n = remaining;
        tick_n      = 1'b0;
        hz_n        = hz;
        err_n       = 1'b0;

        case (state)
            IDLE: begin
                if (xfer) begin
                    if (cfg_bad) begin
                        err_n = 1'b1;
                    end else begin
                        div_n     = cfg.cfg_div;
                        oneshot_n = cfg.cfg_oneshot;
                        pulses_n  = cfg.cfg_pulses;
                    end
                end
                // A config accepted on the start edge is the one the run uses.
                if (!stop && start) begin
                    state_n     = RUN;
                    count_n     = '0;
                    remaining_n = pulses_n;
                end
            end
            RUN: begin
                // stop wins over a coincident wrap: no tick, no hz toggle, no decrement.
                if (stop) begin
                    state_n = IDLE;
                end else if (wrap) begin
                    count_n = '0;
                    tick_n  = 1'b1;
                    hz_n    = ~hz;
                    if (oneshot_reg) begin
                        remaining_n = remaining - 8'd1;
                        if (remaining == 8'd1) begin
                            state_n = DONE;
                        end
                    end
                end else begin
                    count_n = count + CNT_W'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n == RUN);
        done_n = (state_n == DONE);
    end

    always_ff @(posedge Mhz or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            div_reg     <= CNT_W'(DEF_DIV);
            oneshot_reg <= 1'b0;
            pulses_reg  <= 8'd1;
            count       <= '0;
            remaining   <= 8'd0;
            tick        <= 1'b0;
            hz          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_n;
            div_reg     <= div_n;
            oneshot_reg <= oneshot_n;
            pulses_reg  <= pulses_n;
            count       <= count_n;
            remaining   <= remaining_n;
            tick        <= tick_n;
            hz          <= hz_n;
            busy        <= busy_n;
            done        <= done_n;
            err         <= err_n;
        end
    end
endmodule

// File: tb/tb_div_ctrl.sv
// Randomized bench for div_ctrl; expected outputs come from tick arithmetic
// over each run (start edge, ratio, pulse count, stop edge).
module tb_div_ctrl;
    localparam int CNT_W   = 28;
    localparam int DEF_DIV = 10;

    logic Mhz = 1'b0;
    logic RST = 1'b0;
    logic start = 1'b0;
    logic stop  = 1'b0;
    logic tick, hz, busy, done, err;

    div_ctrl_if #(.CNT_W(CNT_W)) cfg ();

    div_ctrl #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
        .Mhz  (Mhz),
        .RST  (RST),
        .cfg  (cfg),
        .start(start),
        .stop (stop),
        .tick (tick),
        .hz   (hz),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    always #5 Mhz = ~Mhz;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: the configuration the block should hold and hz level.
    int m_div = DEF_DIV;
    bit m_one = 1'b0;
    int m_pul = 1;
    bit m_hz  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clk_step();
        @(posedge Mhz);
        #1;
    endtask

    task automatic do_cfg(input int d, input bit one, input int p);
        bit bad;
        check("cfg_ready_idle", cfg.cfg_ready, 1);
        cfg.cfg_valid   = 1'b1;
        cfg.cfg_div     = CNT_W'(d);
        cfg.cfg_oneshot = one;
        cfg.cfg_pulses  = 8'(p);
        clk_step();
        cfg.cfg_valid = 1'b0;
        bad = (d < 2) || (one && (p == 0));
        check("cfg_err", err, bad);
        if (!bad) begin
            m_div = d;
            m_one = one;
            m_pul = p;
        end
        clk_step();
        check("cfg_err_width", err, 0);
    endtask

    // One run from IDLE: start (optionally with a config on the same edge),
    // optional stop at relative edge stop_at, optional ignored config pokes.
    task automatic run_session(input bit with_cfg, input int cd, input bit co, input int cp,
                               input int stop_at_in, input bit poke);
        bit bad, one, tickx;
        int d, n, s_eff, end_e, ready_e, len, ticks, stop_at;
        stop_at = stop_at_in;
        if (with_cfg) begin
            cfg.cfg_valid   = 1'b1;
            cfg.cfg_div     = CNT_W'(cd);
            cfg.cfg_oneshot = co;
            cfg.cfg_pulses  = 8'(cp);
        end
        start = 1'b1;
        clk_step();
        start = 1'b0;
        cfg.cfg_valid = 1'b0;
        bad = with_cfg && ((cd < 2) || (co && (cp == 0)));
        if (with_cfg && !bad) begin
            m_div = cd;
            m_one = co;
            m_pul = cp;
        end
        check("start_err", err, bad);
        check("start_busy", busy, 1);
        check("start_ready", cfg.cfg_ready, 0);
        check("start_tick", tick, 0);

        d = m_div;
        one = m_one;
        n = m_pul;
        if (!one && stop_at == 0) stop_at = 12;
        if (one) begin
            s_eff = (stop_at > 0 && stop_at <= n * d) ? stop_at : (1 << 30);
            len   = n * d + 3;
        end else begin
            s_eff = stop_at;
            len   = stop_at + 3;
        end
        if (one && (n * d < s_eff)) begin
            end_e   = n * d;
            ready_e = end_e + 1;
        end else begin
            end_e   = s_eff;
            ready_e = s_eff;
        end

        ticks = 0;
        for (int j = 1; j <= len; j++) begin
            stop = (j == stop_at);
            if (poke && j <= ready_e) begin
                cfg.cfg_valid   = 1'($urandom_range(0, 1));
                cfg.cfg_div     = CNT_W'($urandom_range(0, 9));
                cfg.cfg_oneshot = 1'($urandom_range(0, 1));
                cfg.cfg_pulses  = 8'($urandom_range(0, 3));
            end else begin
                cfg.cfg_valid = 1'b0;
            end
            clk_step();
            tickx = ((j % d) == 0) && (j < s_eff) && (!one || (j / d) <= n);
            if (tickx) ticks++;
            check("tick", tick, tickx);
            check("hz", hz, m_hz ^ ticks[0]);
            check("busy", busy, j < end_e);
            check("done", done, one && (j == n * d) && (n * d < s_eff));
            check("cfg_ready", cfg.cfg_ready, j >= ready_e);
            check("err_run", err, 0);
        end
        stop = 1'b0;
        cfg.cfg_valid = 1'b0;
        m_hz = m_hz ^ ticks[0];
    endtask

    initial begin
        cfg.cfg_valid   = 1'b0;
        cfg.cfg_div     = '0;
        cfg.cfg_oneshot = 1'b0;
        cfg.cfg_pulses  = 8'd0;

        #17;
        check("rst_tick", tick, 0);
        check("rst_hz", hz, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ready", cfg.cfg_ready, 1);
        RST = 1'b1;
        clk_step();
        check("idle_ready", cfg.cfg_ready, 1);

        // Default ratio straight out of reset.
        run_session(1'b0, 0, 1'b0, 0, 25, 1'b0);
        // div=4 continuous with ignored config offers during RUN.
        do_cfg(4, 1'b0, 1);
        run_session(1'b0, 0, 1'b0, 0, 18, 1'b1);
        // div=2 one-shot, 3 pulses; hz then holds.
        do_cfg(2, 1'b1, 3);
        run_session(1'b0, 0, 1'b0, 0, 0, 1'b0);
        clk_step();
        clk_step();
        check("hz_hold", hz, m_hz);
        check("hz_hold_one", hz, 1);
        // Rejected configs keep the prior ratio.
        do_cfg(1, 1'b0, 1);
        do_cfg(5, 1'b1, 0);
        run_session(1'b0, 0, 1'b0, 0, 0, 1'b0);
        // div=5 continuous, stop on the second wrap.
        do_cfg(5, 1'b0, 1);
        run_session(1'b0, 0, 1'b0, 0, 10, 1'b0);
        check("hz_after_stop", hz, 1);
        // start and stop together in IDLE.
        start = 1'b1;
        stop  = 1'b1;
        clk_step();
        start = 1'b0;
        stop  = 1'b0;
        check("startstop_busy", busy, 0);
        check("startstop_ready", cfg.cfg_ready, 1);
        clk_step();
        check("startstop_busy2", busy, 0);
        check("startstop_tick", tick, 0);
        // Config and start on the same edge.
        run_session(1'b1, 3, 1'b1, 2, 0, 1'b0);

        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(0, 1) == 1)
                do_cfg($urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 4));
            run_session(1'($urandom_range(0, 1)), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                        $urandom_range(0, 4), $urandom_range(0, 30), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset mid-run while tick and hz are high.
        do_cfg(3, 1'b0, 1);
        start = 1'b1;
        clk_step();
        start = 1'b0;
        repeat (3) clk_step();
        check("pre_rst_tick", tick, 1);
        #2 RST = 1'b0;
        #1;
        check("arst_tick", tick, 0);
        check("arst_hz", hz, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_err", err, 0);
        check("arst_ready", cfg.cfg_ready, 1);
        #10 RST = 1'b1;
        m_div = DEF_DIV;
        m_one = 1'b0;
        m_pul = 1;
        m_hz  = 1'b0;
        clk_step();
        check("post_rst_busy", busy, 0);
        run_session(1'b0, 0, 1'b0, 0, 15, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/div_ctrl.md
# div_ctrl

Programmable controller for the board's tick/clock-divider path. It holds the active divide ratio, accepts new configurations through a valid/ready handshake, and starts and stops counting on command. It runs in continuous or one-shot (N ticks) mode and emits a single-cycle `tick` enable, a toggling `hz` output and status flags. Downstream blocks (display scan, LED blink, step clock) consume `tick` as a clock enable in the same `Mhz` domain.

## Interface
- `CNT_W`, 28: divide counter and ratio width.
- `DEF_DIV`, 100_000_000: divide ratio loaded at reset; must be ≥ 2.

- `Mhz`  in  1  system clock; all logic on its rising edge.
- `RST`  in  1  asynchronous, active-low reset (asserted when 0).
- `cfg_valid`  in  1  configuration offered.
- `cfg_ready`  out  1  configuration can be accepted; high only in IDLE.
- `cfg_div`  in  CNT_W  ticks are spaced `cfg_div` clock cycles apart.
- `cfg_oneshot`  in  1  0 = continuous, 1 = stop after `cfg_pulses` ticks.
- `cfg_pulses`  in  8  tick count for one-shot mode.
- `start`  in  1  begin counting; level-sampled, acted on only in IDLE.
- `stop`  in  1  abort counting; acted on only in RUN.
- `tick`  out  1  registered one-cycle pulse per elapsed period.
- `hz`  out  1  toggles on every tick; period is 2×div cycles.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse when a one-shot sequence completes.
- `err`  out  1  one-cycle pulse when a configuration is rejected.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- Reset values: `div_reg`=DEF_DIV, `oneshot_reg`=0, `pulses_reg`=1, count=0, remaining=0, `tick`=0, `hz`=0, `busy`=0, `done`=0, `err`=0. `cfg_ready` is 1 because the block is in IDLE.
- Config handshake: a transfer occurs on an edge where `cfg_valid && cfg_ready`.
  - Reject when `cfg_div < 2`, or when `cfg_oneshot`=1 and `cfg_pulses`=0.
  - On reject: `err`=1 for one cycle and all registers are left unchanged.
  - Otherwise load `div_reg`, `oneshot_reg` and `pulses_reg`.
  - Outside IDLE, `cfg_ready`=0 and `cfg_valid` is ignored.
- IDLE:
  - `stop` high → remain in IDLE. `stop` beats `start` on the same edge.
  - Else `start` high → RUN, count←0, remaining←`pulses_reg`.
  - If a config transfer and `start` fall on the same edge, the config is accepted and RUN uses the newly loaded values.
- RUN:
  - count increments each cycle, width CNT_W with no overflow (count < `div_reg` always).
  - When count == `div_reg`−1: count←0, `tick`←1, `hz`←~`hz`.
  - In one-shot mode the same edge also decrements remaining. If remaining was 1 → DONE.
  - `stop` high → IDLE. `stop` suppresses a coincident tick: no tick, no `hz` toggle, and remaining is not decremented.
- DONE: `done`=1 for exactly this one cycle, then IDLE.
- `hz` holds its value when leaving RUN and is cleared only by reset.
- Reset asserted at any time forces all reset values immediately, independent of the clock.

## Timing
- `start` sampled at edge E0 → RUN after E0.
- Ticks:
  - The first `tick` is high in the cycle after edge E0+div.
  - Subsequent ticks are exactly div cycles apart.
  - `tick` is never high for two consecutive cycles, since div ≥ 2.
- `busy` is registered and equals (state==RUN), so it rises the cycle after the `start` edge.
- One-shot end:
  - The final `tick` and the entry to DONE occur on the same edge.
  - `done` is high in the cycle in which that final `tick` is also high.
  - `busy` falls on that same edge.
  - `cfg_ready` returns to 1 one cycle later, on entry to IDLE.
- `err` is high in the cycle after the rejecting edge.
- `stop` sampled at edge S → IDLE after S. No `tick` is asserted after S.

## Test plan
- Reset released, no config, `start` pulsed → first `tick` follows the `start` edge by 100_000_000 cycles; `cfg_ready`=1 before start. Run this case with DEF_DIV overridden to 10 for simulation: `tick` 10 cycles after start.
- Config div=4, continuous, then `start` → `tick` every 4 cycles and `hz` period 8. `cfg_valid` during RUN is not accepted (`cfg_ready`=0) and the tick spacing stays 4.
- Config div=2, one-shot, pulses=3, then `start` → exactly 3 ticks spaced 2 cycles apart. `done` coincides with the 3rd tick, then IDLE, then `hz`=1 holds.
- Config div=1, then config oneshot with pulses=0 → each gives one `err` pulse. A following `start` still ticks at the prior ratio.
- div=5, continuous: `stop` on the same edge as the 2nd wrap → no 2nd tick and `hz` stays 1. `start` and `stop` together in IDLE → stays IDLE.
- `RST` driven low mid-RUN, between clock edges → `tick`, `hz`, `busy`, `done` and `err` go to 0 immediately, `div_reg` returns to DEF_DIV, and the state is IDLE after release.
